// File: rtl/axi4_stream_len_pkg.sv
// Shared types for the packet-length controller.
package axi4_stream_len_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } len_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; the clock and reset travel with the bus.
interface axi4_stream_if #(
    parameter int DN = 1,
    parameter int DW = 8 * DN
);
    logic          ACLK;
    logic          ARESETn;
    logic [DW-1:0] TDATA;
    logic [DN-1:0] TKEEP;
    logic          TLAST;
    logic          TVALID;
    logic          TREADY;

    modport master (input ACLK, ARESETn, TREADY, output TDATA, TKEEP, TLAST, TVALID);
    modport slave  (input ACLK, ARESETn, TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/axi4_stream_kcnt.sv
// Number of valid samples in one transfer (popcount of TKEEP).
module axi4_stream_kcnt #(
    parameter int DN = 1
) (
    input  logic [DN-1:0]            keep,
    output logic [$clog2(DN+1)-1:0]  cnt
);
    localparam int KW = $clog2(DN + 1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DN; i++) begin
            cnt = cnt + KW'(keep[i]);
        end
    end
endmodule

// File: rtl/axi4_stream_len_ctl.sv
// Packet-length sequencer: gates the stream by run state, forces TLAST every
// len_l transfers, ends the run after num_l packets or on a stop request.
//
// state | meaning
// IDLE  | stream discarded (TREADY=1), waiting for start
// RUN   | stream passed through, packets closed by length or upstream TLAST
// STOP  | stop requested mid-packet; next transfer closes it with TLAST
module axi4_stream_len_ctl
    import axi4_stream_len_pkg::*;
#(
    parameter int DN = 1,
    parameter int CW = 32
) (
    axi4_stream_if.slave    sti,
    axi4_stream_if.master   sto,
    input  logic            ctl_rst,
    input  logic            ctl_str,
    input  logic            ctl_stp,
    input  logic [CW-1:0]   cfg_len,
    input  logic [CW-1:0]   cfg_num,
    output logic            sts_run,
    output logic [CW-1:0]   sts_cur,
    output logic [CW-1:0]   sts_lst,
    output logic [CW-1:0]   sts_pkt,
    output logic            evt_done
);
    localparam int KW = $clog2(DN + 1);

    len_state_t     state, state_nxt;
    logic [CW-1:0]  len_l, len_nxt, num_l, num_nxt;
    logic [CW-1:0]  acc, acc_nxt, cur_nxt, lst_nxt, pkt_nxt;
    logic           done_nxt;
    logic [KW-1:0]  kcnt;
    logic           active, xfer, len_hit, tlast;

    axi4_stream_kcnt #(.DN(DN)) u_kcnt (
        .keep (sti.TKEEP),
        .cnt  (kcnt)
    );

    assign active  = (state != IDLE);
    assign xfer    = active & sti.TVALID & sto.TREADY;
    assign len_hit = (len_l != '0) && (sts_cur + CW'(1) == len_l);
    assign tlast   = sti.TLAST | len_hit | (state == STOP);

    assign sto.TDATA  = sti.TDATA;
    assign sto.TKEEP  = sti.TKEEP;
    assign sto.TVALID = active & sti.TVALID;
    assign sto.TLAST  = active & tlast;
    assign sti.TREADY = active ? sto.TREADY : 1'b1;
    assign sts_run    = active;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        len_nxt   = len_l;
        num_nxt   = num_l;
        cur_nxt   = sts_cur;
        acc_nxt   = acc;
        lst_nxt   = sts_lst;
        pkt_nxt   = sts_pkt;

        // counters first, so the stop decision below sees the updated sts_cur
        if (xfer) begin
            if (tlast) begin
                cur_nxt = '0;
                lst_nxt = acc + CW'(kcnt);
                acc_nxt = '0;
                pkt_nxt = sts_pkt + CW'(1);
            end else begin
                cur_nxt = sts_cur + CW'(1);
                acc_nxt = acc + CW'(kcnt);
            end
        end

        unique case (state)
            IDLE: begin
                if (ctl_str && !ctl_stp) begin
                    state_nxt = RUN;
                    len_nxt   = cfg_len;
                    num_nxt   = cfg_num;
                    cur_nxt   = '0;
                    acc_nxt   = '0;
                    pkt_nxt   = '0;
                end
            end
            RUN: begin
                if (xfer && tlast && (num_l != '0) && (pkt_nxt == num_l)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (ctl_stp) begin
                    if (cur_nxt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (xfer) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (ctl_rst) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            len_nxt   = '0;
            num_nxt   = '0;
            cur_nxt   = '0;
            acc_nxt   = '0;
            lst_nxt   = '0;
            pkt_nxt   = '0;
        end
    end

    always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
        if (!sti.ARESETn) begin
            state    <= IDLE;
            evt_done <= 1'b0;
            len_l    <= '0;
            num_l    <= '0;
            sts_cur  <= '0;
            acc      <= '0;
            sts_lst  <= '0;
            sts_pkt  <= '0;
        end else begin
            state    <= state_nxt;
            evt_done <= done_nxt;
            len_l    <= len_nxt;
            num_l    <= num_nxt;
            sts_cur  <= cur_nxt;
            acc      <= acc_nxt;
            sts_lst  <= lst_nxt;
            sts_pkt  <= pkt_nxt;
        end
    end
endmodule

// File: tb/tb_axi4_stream_len_ctl.sv
// Scoreboard bench for axi4_stream_len_ctl: driver pushes expected beats, monitor pops.
module tb_axi4_stream_len_ctl;
    localparam int DN = 4;
    localparam int CW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.DN(DN), .DW(DW)) sti_if ();
    axi4_stream_if #(.DN(DN), .DW(DW)) sto_if ();
    assign sti_if.ACLK    = clk;
    assign sto_if.ACLK    = clk;
    assign sti_if.ARESETn = rst_n;
    assign sto_if.ARESETn = rst_n;

    logic          ctl_rst = 1'b0, ctl_str = 1'b0, ctl_stp = 1'b0;
    logic [CW-1:0] cfg_len = '0, cfg_num = '0;
    logic          sts_run, evt_done;
    logic [CW-1:0] sts_cur, sts_lst, sts_pkt;

    axi4_stream_len_ctl #(.DN(DN), .CW(CW)) dut (
        .sti      (sti_if),
        .sto      (sto_if),
        .ctl_rst  (ctl_rst),
        .ctl_str  (ctl_str),
        .ctl_stp  (ctl_stp),
        .cfg_len  (cfg_len),
        .cfg_num  (cfg_num),
        .sts_run  (sts_run),
        .sts_cur  (sts_cur),
        .sts_lst  (sts_lst),
        .sts_pkt  (sts_pkt),
        .evt_done (evt_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [DN-1:0] keep;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    done_seen = 0;
    int    done_exp = 0;
    int    beat_no = 0;
    bit    rnd_rdy = 1'b0;

    // reference model: run flag, stop-pending flag, position in packet, totals
    bit          m_run = 1'b0, m_stop = 1'b0;
    int unsigned m_len = 0, m_num = 0, m_cur = 0, m_acc = 0, m_lst = 0, m_pkt = 0;

    always @(posedge clk) begin
        #1;
        sto_if.TREADY = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && sto_if.TVALID && sto_if.TREADY) begin
            checks++;
            beat_no++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat%0d got unexpected beat data=%h last=%b required none",
                         beat_no, sto_if.TDATA, sto_if.TLAST);
            end else begin
                mon_e = exp_q.pop_front();
                if (sto_if.TDATA !== mon_e.data || sto_if.TKEEP !== mon_e.keep ||
                    sto_if.TLAST !== mon_e.last) begin
                    errors++;
                    $display("FAIL beat%0d got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                             beat_no, sto_if.TDATA, sto_if.TKEEP, sto_if.TLAST,
                             mon_e.data, mon_e.keep, mon_e.last);
                end
            end
        end
        if (evt_done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic model_clear();
        m_run = 1'b0; m_stop = 1'b0;
        m_len = 0; m_num = 0; m_cur = 0; m_acc = 0; m_lst = 0; m_pkt = 0;
    endtask

    task automatic start(input int unsigned len, input int unsigned num);
        cfg_len = len;
        cfg_num = num;
        ctl_str = 1'b1;
        tick();
        ctl_str = 1'b0;
        if (!m_run) begin
            m_run = 1'b1; m_stop = 1'b0;
            m_len = len; m_num = num;
            m_cur = 0; m_acc = 0; m_pkt = 0;
        end
    endtask

    task automatic stop();
        ctl_stp = 1'b1;
        tick();
        ctl_stp = 1'b0;
        if (m_run && !m_stop) begin
            if (m_cur == 0) begin
                m_run = 1'b0;
                done_exp++;
            end else begin
                m_stop = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [DN-1:0] keep, input logic ulast);
        beat_t b;
        int    n;
        b.data = DW'($urandom);
        b.keep = keep;
        b.last = 1'b0;
        if (m_run) begin
            b.last = ulast || (m_len != 0 && m_cur + 1 == m_len) || m_stop;
            exp_q.push_back(b);
            if (b.last) begin
                m_lst = m_acc + $countones(keep);
                m_acc = 0;
                m_cur = 0;
                m_pkt++;
                if (m_stop || (m_num != 0 && m_pkt == m_num)) begin
                    m_run  = 1'b0;
                    m_stop = 1'b0;
                    done_exp++;
                end
            end else begin
                m_cur++;
                m_acc += $countones(keep);
            end
        end
        sti_if.TDATA  = b.data;
        sti_if.TKEEP  = keep;
        sti_if.TLAST  = ulast;
        sti_if.TVALID = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sti_if.TREADY && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout got no TREADY required TREADY within 200 cycles");
        end
        @(posedge clk);
        #1;
        sti_if.TVALID = 1'b0;
        sti_if.TLAST  = 1'b0;
    endtask

    task automatic check_sts(input string tag);
        tick();
        tick();
        check({tag, "_run"}, CW'(sts_run), CW'(m_run));
        check({tag, "_cur"}, sts_cur, m_cur);
        check({tag, "_lst"}, sts_lst, m_lst);
        check({tag, "_pkt"}, sts_pkt, m_pkt);
        check({tag, "_done"}, done_seen, done_exp);
    endtask

    initial begin
        sti_if.TDATA  = '0;
        sti_if.TKEEP  = '0;
        sti_if.TLAST  = 1'b0;
        sti_if.TVALID = 1'b0;
        repeat (3) tick();
        check("reset_evt_done", CW'(evt_done), '0);
        check_sts("reset");
        rst_n = 1'b1;
        tick();

        // fixed length 8, two packets, then input discarded
        start(8, 2);
        for (int i = 0; i < 20; i++) send(4'hf, 1'b0);
        check_sts("len8num2");

        // continuous, stop after 5 beats closes on the 6th
        start(0, 0);
        for (int i = 0; i < 5; i++) send(4'hf, 1'b0);
        stop();
        check("stop_pending_run", CW'(sts_run), 1);
        send(4'hf, 1'b0);
        send(4'hf, 1'b0);
        check_sts("stop6");

        // upstream TLAST mid-packet restarts the length count
        start(8, 0);
        send(4'hf, 1'b0);
        send(4'hf, 1'b0);
        send(4'h3, 1'b1);
        check_sts("uplast");
        for (int i = 0; i < 8; i++) send(4'hf, 1'b0);
        check_sts("uplast_next");
        stop();
        check_sts("stop_cur0");

        // random backpressure and random traffic
        rnd_rdy = 1'b1;
        start(5, 3);
        for (int i = 0; i < 30; i++) send(DN'($urandom), $urandom_range(0, 7) == 0);
        check_sts("rnd_num3");
        start($urandom_range(1, 6), 0);
        for (int i = 0; i < 40; i++) send(DN'($urandom), $urandom_range(0, 9) == 0);
        stop();
        send(DN'($urandom), 1'b0);
        check_sts("rnd_stop");
        rnd_rdy = 1'b0;
        tick();

        // start and stop together in IDLE, stop in IDLE, start while running
        ctl_str = 1'b1;
        ctl_stp = 1'b1;
        tick();
        ctl_str = 1'b0;
        ctl_stp = 1'b0;
        stop();
        send(4'hf, 1'b0);
        check_sts("str_stp_idle");
        start(4, 0);
        send(4'h1, 1'b0);
        send(4'h1, 1'b0);
        start(2, 0);
        send(4'h1, 1'b0);
        send(4'h1, 1'b0);
        send(4'h1, 1'b0);
        check_sts("restart_ignored");

        // asynchronous reset mid-packet
        stop();
        start(8, 0);
        for (int i = 0; i < 3; i++) send(4'hf, 1'b0);
        rst_n = 1'b0;
        tick();
        model_clear();
        check_sts("arst_mid");
        rst_n = 1'b1;
        tick();

        // synchronous clear mid-packet
        start(8, 0);
        for (int i = 0; i < 3; i++) send(4'hf, 1'b0);
        ctl_rst = 1'b1;
        tick();
        ctl_rst = 1'b0;
        model_clear();
        send(4'hf, 1'b0);
        check_sts("crst_mid");

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
